data_mem_responder: RTL

Memory-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready handshake, performs the access on a byte-addressed little-endian array, and returns a response after a fixed, parameterised latency. RISC-V `funct3` encodes the access size and signedness directly. It replaces the zero-latency data memory when the core moves to a handshaked pipelined memory stage, and it serves as the memory model for stall and hazard testing.

---
 rtl/data_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one load/store in flight, fixed response latency,
// byte-addressed little-endian storage with RISC-V funct3 size/sign decoding.
module data_mem_responder #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt;
   logic [7:0]      mem [DEPTH];
   logic [63:0]     pend_rdata;
   logic            pend_err;

   logic            accept;
   logic [3:0]      size_bytes;
   logic [2:0]      align_mask;
   logic [64:0]     end_addr;
   logic            req_bad;
   logic [AW-1:0]   idx;
   logic [63:0]     raw;
   logic [63:0]     load_data;
   logic [63:0]     new_rdata;

   assign accept = req_valid && (state == S_IDLE);
   assign idx    = req_addr[AW-1:0];

   // Range check runs on a 65-bit sum so addresses near 2^64 cannot wrap into range.
   always_comb begin
      size_bytes = 4'd1 << req_funct3[1:0];
      case (req_funct3[1:0])
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
      end_addr = {1'b0, req_addr} + 65'(size_bytes);
      req_bad  = (req_funct3 == 3'b111)
               || (req_write && req_funct3[2])
               || (|(req_addr[2:0] & align_mask))
               || (end_addr > 65'(DEPTH));
   end

   always_comb begin
      raw = '0;
      for (int unsigned i = 0; i < 8; i++)
         raw[8*i +: 8] = mem[idx + AW'(i)];
   end

   always_comb begin
      case (req_funct3)
         3'b000:  load_data = {{56{raw[7]}},  raw[7:0]};
         3'b001:  load_data = {{48{raw[15]}}, raw[15:0]};
         3'b010:  load_data = {{32{raw[31]}}, raw[31:0]};
         3'b100:  load_data = {56'd0, raw[7:0]};
         3'b101:  load_data = {48'd0, raw[15:0]};
         3'b110:  load_data = {32'd0, raw[31:0]};
         default: load_data = raw;
      endcase
      new_rdata = (req_bad || req_write) ? '0 : load_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (accept && req_write && !req_bad) begin
         for (int unsigned i = 0; i < 8; i++)
            if (i < 32'(size_bytes))
               mem[idx + AW'(i)] <= req_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (req_valid) state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
         S_WAIT: if (cnt == CW'(1)) state_next = S_RESP;
         S_RESP: if (resp_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == S_IDLE);
      resp_valid = (state == S_RESP);
   end

   // Response outputs only update on entry to RESP so they hold through IDLE and WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         pend_rdata <= '0;
         pend_err   <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            cnt        <= CW'(LATENCY - 1);
            pend_rdata <= new_rdata;
            pend_err   <= req_bad;
         end else if (state == S_WAIT) begin
            cnt <= cnt - CW'(1);
         end
         if (state_next == S_RESP && state == S_IDLE) begin
            resp_rdata <= new_rdata;
            resp_err   <= req_bad;
         end else if (state_next == S_RESP && state == S_WAIT) begin
            resp_rdata <= pend_rdata;
            resp_err   <= pend_err;
         end
      end
   end

endmodule
